// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped data cache controller.
package dcache_pkg;

    typedef enum logic [2:0] {IDLE, WB, RD, WAIT, DONE} state_t;

    localparam int WORDS_PER_LINE = 4;
    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 16;
    localparam int OFFSET_W       = 2;
    localparam int OFFSET_LSB     = 1;
    localparam int INDEX_LSB      = OFFSET_LSB + OFFSET_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef word_t [WORDS_PER_LINE-1:0] line_t;

    function automatic int index_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_width(input int num_lines);
        return ADDR_W - INDEX_LSB - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid, dirty and data storage: one async read port, a word-write port
// and a whole-line fill port that also installs the tag and marks the line clean.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = 4,
    parameter int TAG_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_index,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    output logic             rd_dirty,
    output line_t            rd_line,
    input  logic             word_en,
    input  logic [IDX_W-1:0] word_index,
    input  logic [1:0]       word_offset,
    input  word_t            word_data,
    input  logic             fill_en,
    input  logic [IDX_W-1:0] fill_index,
    input  logic [TAG_W-1:0] fill_tag,
    input  line_t            fill_line
);

    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    line_t                data_mem [NUM_LINES];
    logic [NUM_LINES-1:0] valid_bits;
    logic [NUM_LINES-1:0] dirty_bits;

    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid_bits[rd_index];
    assign rd_dirty = dirty_bits[rd_index];
    assign rd_line  = data_mem[rd_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (fill_en) begin
            valid_bits[fill_index] <= 1'b1;
            dirty_bits[fill_index] <= 1'b0;
        end else if (word_en) begin
            dirty_bits[word_index] <= 1'b1;
        end
    end

    // Payload storage needs no reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= fill_line;
        end else if (word_en) begin
            data_mem[word_index][word_offset] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller with a fixed-latency backing memory.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int MEM_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    localparam int IDX_W = index_width(NUM_LINES);
    localparam int TAG_W = tag_width(NUM_LINES);

    state_t state, next_state;

    logic [1:0]       offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             good_req, bad_req, hit;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid, rd_dirty;
    line_t            rd_line, fill_line;
    logic             word_en, fill_en;
    logic [1:0]       cnt_k;
    logic [MEM_LAT-1:0]      pipe_vld;
    logic [MEM_LAT-1:0][1:0] pipe_k;
    logic [2:0][15:0] fill_buf;
    logic             capture, last_cap;
    logic [1:0]       cap_k;

    assign offset   = Addr[INDEX_LSB-1:OFFSET_LSB];
    assign index    = Addr[INDEX_LSB +: IDX_W];
    assign tag      = Addr[ADDR_W-1:INDEX_LSB+IDX_W];
    assign good_req = (Rd ^ Wr) & ~Addr[0];
    assign bad_req  = (Rd & Wr) | ((Rd ^ Wr) & Addr[0]);
    assign hit      = rd_valid && (rd_tag == tag);

    assign capture   = pipe_vld[MEM_LAT-1];
    assign cap_k     = pipe_k[MEM_LAT-1];
    assign last_cap  = capture && (cap_k == 2'd3);
    assign fill_line = {mem_rdata, fill_buf[2], fill_buf[1], fill_buf[0]};

    dcache_array #(.NUM_LINES(NUM_LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
        .clk(clk), .rst(rst),
        .rd_index(index), .rd_tag(rd_tag), .rd_valid(rd_valid), .rd_dirty(rd_dirty), .rd_line(rd_line),
        .word_en(word_en), .word_index(index), .word_offset(offset), .word_data(DataIn),
        .fill_en(fill_en), .fill_index(index), .fill_tag(tag), .fill_line(fill_line)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (good_req && !hit) next_state = (rd_valid && rd_dirty) ? WB : RD;
            WB:   if (cnt_k == 2'd3) next_state = RD;
            RD:   if (cnt_k == 2'd3) next_state = WAIT;
            WAIT: if (last_cap) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        DataOut   = '0;
        Done      = 1'b0;
        Stall     = 1'b0;
        CacheHit  = 1'b0;
        err       = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        word_en   = 1'b0;
        fill_en   = 1'b0;
        case (state)
            IDLE: begin
                err = bad_req;
                if (good_req && hit) begin
                    Done     = 1'b1;
                    CacheHit = 1'b1;
                    DataOut  = Rd ? rd_line[offset] : '0;
                    word_en  = Wr;
                end else if (good_req) begin
                    Stall = 1'b1;
                end
            end
            WB: begin
                Stall     = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {rd_tag, index, cnt_k, 1'b0};
                mem_wdata = rd_line[cnt_k];
            end
            RD: begin
                Stall    = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {tag, index, cnt_k, 1'b0};
            end
            WAIT: begin
                Stall   = 1'b1;
                fill_en = last_cap;
            end
            DONE: begin
                Done    = 1'b1;
                DataOut = Rd ? rd_line[offset] : '0;
                word_en = Wr;
            end
            default: ;
        endcase
    end

    // Each read issue travels down a MEM_LAT-deep tag pipe so its word is
    // captured exactly when the memory returns it; reset flushes in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_k    <= '0;
            pipe_vld <= '0;
            pipe_k   <= '0;
        end else begin
            if (state == WB || state == RD) cnt_k <= cnt_k + 2'd1;
            pipe_vld[0] <= (state == RD);
            pipe_k[0]   <= cnt_k;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_k[i]   <= pipe_k[i-1];
            end
            if (capture) begin
                case (cap_k)
                    2'd0: fill_buf[0] <= mem_rdata;
                    2'd1: fill_buf[1] <= mem_rdata;
                    2'd2: fill_buf[2] <= mem_rdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_q, miss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state == IDLE && good_req) begin
            if (hit && hit_q != 16'hFFFF)   hit_q  <= hit_q + 16'd1;
            if (!hit && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Table-driven scoreboard bench for dcache_ctrl with a fixed-latency memory model.
module tb_dcache_ctrl;

    localparam int NL = 16;
    localparam int ML = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] Addr = '0, DataIn = '0;
    logic        Rd = 1'b0, Wr = 1'b0;
    logic [15:0] DataOut, mem_addr, mem_wdata, mem_rdata, hit_cnt, miss_cnt;
    logic        Done, Stall, CacheHit, err, mem_rd, mem_wr;

    always #5 clk = ~clk;

    dcache_ctrl #(.NUM_LINES(NL), .MEM_LAT(ML)) dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    typedef struct {
        logic rd; logic wr; logic [15:0] addr; logic [15:0] din; logic is_err;
        logic chk_data; logic [15:0] data; logic hit; int lat; int rds;
    } vec_t;
    typedef struct { logic chk_data; logic [15:0] data; logic hit; int lat; int start; } exp_t;
    typedef struct { logic [15:0] addr; logic [15:0] data; } wb_t;

    vec_t        vecs[12];
    exp_t        expq[$];
    wb_t         wbq[$];
    exp_t        mon_e;
    wb_t         mon_w;
    logic [15:0] bmem [32768];
    logic [15:0] lat_data [ML];
    int          tests = 0, fails = 0, cyc = 0, rd_strobes = 0, rd_k = 0;
    logic [15:0] cur_addr = '0;

    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'hC3C3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Backing memory answers every read exactly ML cycles after the strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr) bmem[mem_addr[15:1]] <= mem_wdata;
        lat_data[0] <= mem_rd ? bmem[mem_addr[15:1]] : 16'hDEAD;
        for (int i = 1; i < ML; i++) lat_data[i] <= lat_data[i-1];
    end
    assign mem_rdata = lat_data[ML-1];

    always @(negedge clk) begin
        if (!rst) begin
            if (Done) begin
                if (expq.size() == 0) checkOutput("unexpected_done", 1, 0);
                else begin
                    mon_e = expq.pop_front();
                    if (mon_e.chk_data) checkOutput("data", DataOut, mon_e.data);
                    checkOutput("cache_hit", CacheHit, mon_e.hit);
                    checkOutput("stall_at_done", Stall, 0);
                    checkOutput("latency", cyc - mon_e.start, mon_e.lat);
                end
            end
            if (mem_wr) begin
                if (wbq.size() == 0) checkOutput("unexpected_wb", 1, 0);
                else begin
                    mon_w = wbq.pop_front();
                    checkOutput("wb_addr", mem_addr, mon_w.addr);
                    checkOutput("wb_data", mem_wdata, mon_w.data);
                end
            end
            if (mem_rd) begin
                checkOutput("rd_addr", mem_addr, {cur_addr[15:3], rd_k[1:0], 1'b0});
                rd_k++;
                rd_strobes++;
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        int waited, rd_base;
        @(posedge clk); #1;
        Addr = v.addr; DataIn = v.din; Rd = v.rd; Wr = v.wr;
        cur_addr = v.addr; rd_k = 0; rd_base = rd_strobes;
        if (v.is_err) begin
            @(negedge clk);
            checkOutput("err", err, 1);
            checkOutput("err_done", Done, 0);
            checkOutput("err_strobes", {mem_rd, mem_wr, Stall}, 0);
            @(posedge clk); #1;
            Rd = 1'b0; Wr = 1'b0;
        end else begin
            expq.push_back('{v.chk_data, v.data, v.hit, v.lat, cyc});
            waited = 0;
            while (expq.size() != 0 && waited < 40) begin
                @(posedge clk);
                waited++;
            end
            if (expq.size() != 0) begin
                checkOutput("done_timeout", 0, 1);
                expq.delete();
            end
            #1;
            Rd = 1'b0; Wr = 1'b0;
            checkOutput("rd_strobe_count", rd_strobes - rd_base, v.rds);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 32768; i++) bmem[i] = pat(16'(i * 2));
        bmem[16'h0040 >> 1] = 16'hBEEF;

        //          rd    wr    addr      din       err   chk   data            hit   lat rds
        vecs[0]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b1, 16'hBEEF,       1'b0, 7,  4};
        vecs[1]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b1, 16'hBEEF,       1'b1, 0,  0};
        vecs[2]  = '{1'b0, 1'b1, 16'h0042, 16'h1234, 1'b0, 1'b0, 16'h0000,       1'b1, 0,  0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0442, 16'h0000, 1'b0, 1'b1, pat(16'h0442),  1'b0, 11, 4};
        vecs[4]  = '{1'b1, 1'b1, 16'h0446, 16'hFFFF, 1'b1, 1'b0, 16'h0000,       1'b0, 0,  0};
        vecs[5]  = '{1'b1, 1'b0, 16'h0041, 16'h0000, 1'b1, 1'b0, 16'h0000,       1'b0, 0,  0};
        vecs[6]  = '{1'b1, 1'b0, 16'h0446, 16'h0000, 1'b0, 1'b1, pat(16'h0446),  1'b1, 0,  0};
        vecs[7]  = '{1'b1, 1'b0, 16'h0042, 16'h0000, 1'b0, 1'b1, 16'h1234,       1'b0, 7,  4};
        vecs[8]  = '{1'b0, 1'b1, 16'h0010, 16'h5A5A, 1'b0, 1'b0, 16'h0000,       1'b0, 7,  4};
        vecs[9]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'h5A5A,       1'b1, 0,  0};
        vecs[10] = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b0, 1'b1, pat(16'hFFFE),  1'b0, 7,  4};
        vecs[11] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b1, 16'hBEEF,       1'b1, 0,  0};

        wbq.push_back('{16'h0040, 16'hBEEF});
        wbq.push_back('{16'h0042, 16'h1234});
        wbq.push_back('{16'h0044, pat(16'h0044)});
        wbq.push_back('{16'h0046, pat(16'h0046)});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_dataout", DataOut, 0);
        checkOutput("reset_mem_addr", mem_addr, 0);
        checkOutput("reset_mem_wdata", mem_wdata, 0);
        checkOutput("reset_flags", {Done, Stall, CacheHit, err, mem_rd, mem_wr}, 0);
        checkOutput("reset_hit_cnt", hit_cnt, 0);
        checkOutput("reset_miss_cnt", miss_cnt, 0);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);
        @(negedge clk);
`ifdef DCACHE_STATS_EN
        checkOutput("hit_cnt", hit_cnt, 2);
        checkOutput("miss_cnt", miss_cnt, 2);
`else
        checkOutput("hit_cnt", hit_cnt, 0);
        checkOutput("miss_cnt", miss_cnt, 0);
`endif
        for (int i = 6; i < 12; i++) applyStimulus(vecs[i]);
        @(negedge clk);
`ifdef DCACHE_STATS_EN
        checkOutput("hit_cnt_final", hit_cnt, 5);
        checkOutput("miss_cnt_final", miss_cnt, 5);
`else
        checkOutput("hit_cnt_final", hit_cnt, 0);
        checkOutput("miss_cnt_final", miss_cnt, 0);
`endif
        checkOutput("wb_pending", wbq.size(), 0);

        // Reset while the refill of 0x0200 is waiting on its last words.
        @(posedge clk); #1;
        Addr = 16'h0200; Rd = 1'b1; cur_addr = 16'h0200; rd_k = 0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("mid_miss_in_wait", {Stall, mem_rd, mem_wr}, 3'b100);
        rst = 1'b1; Rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_strobes", {mem_rd, mem_wr}, 0);
        checkOutput("abort_flags", {Done, Stall, CacheHit, err}, 0);
        repeat (4) @(negedge clk);
        checkOutput("abort_idle", {Done, Stall, mem_rd, mem_wr}, 0);
        applyStimulus('{1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b1, pat(16'h0200), 1'b0, 7, 4});
        applyStimulus('{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0, 7, 4});

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
